// File: rtl/pg2pp_align_fifo.sv
// Pixel FIFO with a programmable timing delay: Vsync/Hsync/DE are delayed by D cycles and the
// buffered pixels are read out aligned to the delayed DE. Optional sticky status: PG2PP_ALIGN_STATUS_EN.
module pg2pp_align_fifo #(
    parameter int RGB_PORT = 1,
    parameter int DEPTH    = 256,
    parameter int DELAY_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Vsync,
    input  logic                      Hsync,
    input  logic                      DE,
    input  logic [RGB_PORT*24-1:0]    Din,
    input  logic [DELAY_W-1:0]        delay_cfg,
    input  logic                      clr_status,
    output logic                      Vs_out,
    output logic                      Hs_out,
    output logic                      De_out,
    output logic [RGB_PORT*24-1:0]    Dout,
    output logic                      valid_out,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      ovf_sticky,
    output logic                      udf_sticky
);

    localparam int DW     = RGB_PORT * 24;
    localparam int AW     = $clog2(DEPTH);
    localparam int SR_LEN = (1 << DELAY_W) + 1;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Delay selection, latched only at a Vsync rising edge
    // ------------------------------------------------------------------
    logic               vs_prev_reg;
    logic [DELAY_W-1:0] act_dly_reg;
    logic               vs_rise;
    logic               dly_change;
    logic [DELAY_W:0]   out_idx;
    logic [DELAY_W:0]   rd_idx;

    assign vs_rise    = Vsync & ~vs_prev_reg;
    assign dly_change = vs_rise & (delay_cfg != act_dly_reg);
    // Stage k holds the input delayed by k+1 cycles: output tap D-1, read-request tap D-2.
    assign out_idx    = {1'b0, act_dly_reg} + 1'b1;
    assign rd_idx     = {1'b0, act_dly_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_reg <= 1'b0;
            act_dly_reg <= '0;
        end else begin
            vs_prev_reg <= Vsync;
            if (vs_rise) begin
                act_dly_reg <= delay_cfg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timing shift registers (Vsync, Hsync, DE)
    // ------------------------------------------------------------------
    logic [2:0] tin;
    logic [2:0] tout;
    logic       rd_en;

    assign tin = {Vsync, Hsync, DE};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sr
            logic [SR_LEN-1:0] sr_reg;

            // A new delay restarts the line so stale timing from the old delay never escapes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_reg <= '0;
                end else if (dly_change) begin
                    sr_reg <= {{(SR_LEN - 1){1'b0}}, tin[gi]};
                end else begin
                    sr_reg <= {sr_reg[SR_LEN-2:0], tin[gi]};
                end
            end

            assign tout[gi] = sr_reg[out_idx];
        end
    endgenerate

    assign {Vs_out, Hs_out, De_out} = tout;
    assign rd_en = g_sr[0].sr_reg[rd_idx];

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] level_next;
    logic        rd;
    logic        wr;
    logic        ovf_evt;
    logic        udf_evt;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    // No bypass: a read against an empty FIFO is an underflow even if a write lands this cycle.
    assign rd      = rd_en & ~empty;
    assign wr      = DE & (~full | rd);
    assign ovf_evt = DE & full & ~rd;
    assign udf_evt = rd_en & empty;

    always_comb begin
        level_next = level;
        case ({wr, rd})
            2'b10:   level_next = level + (AW + 1)'(1);
            2'b01:   level_next = level - (AW + 1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level      <= '0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (rd) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
            level <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage and registered read port
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= Din;
        end
    end

    // On a full-FIFO read+write the slot is read before it is overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dout      <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd;
            if (rd) begin
                Dout <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status
    // ------------------------------------------------------------------
`ifdef PG2PP_ALIGN_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_sticky <= 1'b1;
            end else if (clr_status) begin
                ovf_sticky <= 1'b0;
            end
            if (udf_evt) begin
                udf_sticky <= 1'b1;
            end else if (clr_status) begin
                udf_sticky <= 1'b0;
            end
        end
    end
`else
    logic unused_status;
    assign unused_status = clr_status | ovf_evt | udf_evt;
    assign ovf_sticky    = 1'b0;
    assign udf_sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_pg2pp_align_fifo.sv
// Directed bench for pg2pp_align_fifo: a DEPTH=256 instance for streaming/delay checks and a
// DEPTH=4 instance for overflow/underflow checks, both fed from the same stimulus.
module tb_pg2pp_align_fifo;

`ifdef PG2PP_ALIGN_STATUS_EN
    localparam logic EXP_STS = 1'b1;
`else
    localparam logic EXP_STS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        Vsync, Hsync, DE;
    logic [23:0] Din;
    logic [3:0]  delay_cfg;
    logic        clr_status;

    logic        a_vs, a_hs, a_de, a_valid, a_full, a_empty, a_ovf, a_udf;
    logic [23:0] a_dout;
    logic [8:0]  a_level;
    logic        b_vs, b_hs, b_de, b_valid, b_full, b_empty, b_ovf, b_udf;
    logic [23:0] b_dout;
    logic [2:0]  b_level;

    int checks   = 0;
    int failures = 0;
    int maxlvl;

    always #5 clk = ~clk;

    pg2pp_align_fifo #(.RGB_PORT(1), .DEPTH(256), .DELAY_W(4)) dut_a (
        .clk(clk), .rst(rst), .Vsync(Vsync), .Hsync(Hsync), .DE(DE), .Din(Din),
        .delay_cfg(delay_cfg), .clr_status(clr_status),
        .Vs_out(a_vs), .Hs_out(a_hs), .De_out(a_de), .Dout(a_dout), .valid_out(a_valid),
        .level(a_level), .full(a_full), .empty(a_empty), .ovf_sticky(a_ovf), .udf_sticky(a_udf)
    );

    pg2pp_align_fifo #(.RGB_PORT(1), .DEPTH(4), .DELAY_W(4)) dut_b (
        .clk(clk), .rst(rst), .Vsync(Vsync), .Hsync(Hsync), .DE(DE), .Din(Din),
        .delay_cfg(delay_cfg), .clr_status(clr_status),
        .Vs_out(b_vs), .Hs_out(b_hs), .De_out(b_de), .Dout(b_dout), .valid_out(b_valid),
        .level(b_level), .full(b_full), .empty(b_empty), .ovf_sticky(b_ovf), .udf_sticky(b_udf)
    );

    typedef struct {
        logic        vs, hs, de;
        logic [23:0] din;
        logic        e_vs, e_hs, e_de;
        logic [23:0] e_dout;
        logic [8:0]  e_level;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [23:0] d);
        Vsync = vs;
        Hsync = hs;
        DE    = de;
        Din   = d;
    endtask

    initial begin
        // Frame of 16 pixels, D=2: outputs mirror the inputs one table row later.
        for (int t = 0; t < 30; t++) begin
            vecs[t].vs      = (t < 2);
            vecs[t].hs      = (t == 2);
            vecs[t].de      = (t >= 4 && t < 20);
            vecs[t].din     = (t >= 4 && t < 20) ? 24'(t - 3) : 24'd0;
            vecs[t].e_vs    = (t >= 1 && t < 3);
            vecs[t].e_hs    = (t == 3);
            vecs[t].e_de    = (t >= 5 && t < 21);
            vecs[t].e_dout  = (t >= 5 && t < 21) ? 24'(t - 4) : ((t >= 21) ? 24'd16 : 24'd0);
            vecs[t].e_level = (t >= 4 && t < 20) ? 9'd1 : 9'd0;
        end

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        delay_cfg  = 4'd0;
        clr_status = 1'b0;
        tick();
        tick();
        check("reset_level", 32'(a_level), 0);
        check("reset_empty", 32'(a_empty), 1);
        check("reset_full", 32'(a_full), 0);
        check("reset_de_out", 32'(a_de), 0);
        check("reset_valid", 32'(a_valid), 0);
        check("reset_dout", 32'(a_dout), 0);
        check("reset_ovf", 32'(a_ovf), 0);
        check("reset_udf", 32'(a_udf), 0);
        rst = 1'b0;
        tick();

        // ---------------- D=2 streaming table ----------------
        for (int t = 0; t < 30; t++) begin
            drive(vecs[t].vs, vecs[t].hs, vecs[t].de, vecs[t].din);
            tick();
            $display("vec %0d: de_in=%0d din=%0d -> de_out=%0d valid=%0d dout=%0d level=%0d",
                     t, vecs[t].de, vecs[t].din, a_de, a_valid, a_dout, a_level);
            check("tbl_vs_out", 32'(a_vs), 32'(vecs[t].e_vs));
            check("tbl_hs_out", 32'(a_hs), 32'(vecs[t].e_hs));
            check("tbl_de_out", 32'(a_de), 32'(vecs[t].e_de));
            check("tbl_valid", 32'(a_valid), 32'(vecs[t].e_de));
            check("tbl_dout", 32'(a_dout), 32'(vecs[t].e_dout));
            check("tbl_level", 32'(a_level), 32'(vecs[t].e_level));
        end

        // ---------------- D=17, 16-pixel burst ----------------
        delay_cfg = 4'd15;
        maxlvl = 0;
        for (int i = 0; i <= 40; i++) begin
            drive(i < 2, i == 2, (i >= 4 && i < 20), (i >= 4 && i < 20) ? 24'(100 + i - 3) : 24'd0);
            tick();
            if (int'(a_level) > maxlvl) maxlvl = int'(a_level);
            if (i == 15) check("d17_vs_before", 32'(a_vs), 0);
            if (i == 16) check("d17_vs_at", 32'(a_vs), 1);
            if (i == 17) check("d17_hs_before", 32'(a_hs), 0);
            if (i == 18) check("d17_hs_at", 32'(a_hs), 1);
            if (i == 19) begin
                check("d17_de_before", 32'(a_de), 0);
                check("d17_level_peak", 32'(a_level), 16);
            end
            if (i == 20) begin
                check("d17_de_first", 32'(a_de), 1);
                check("d17_dout_first", 32'(a_dout), 101);
                check("d17_valid_first", 32'(a_valid), 1);
                check("d17_level_after_rd", 32'(a_level), 15);
            end
            if (i == 35) begin
                check("d17_dout_last", 32'(a_dout), 116);
                check("d17_de_last", 32'(a_de), 1);
            end
            if (i == 36) begin
                check("d17_de_end", 32'(a_de), 0);
                check("d17_valid_end", 32'(a_valid), 0);
            end
            if (i == 40) begin
                check("d17_level_drained", 32'(a_level), 0);
                check("d17_empty_drained", 32'(a_empty), 1);
            end
        end
        check("d17_max_level", 32'(maxlvl), 16);

        // ---------------- mid-frame delay change ignored ----------------
        for (int i = 0; i <= 25; i++) begin
            delay_cfg = (i < 3) ? 4'd0 : 4'd7;
            drive(i == 0 || i == 10, 1'b0, i == 5 || i == 13,
                  (i == 5) ? 24'd55 : ((i == 13) ? 24'd77 : 24'd0));
            tick();
            if (i == 1) check("mid_vs_d2", 32'(a_vs), 1);
            if (i == 5) check("mid_de_before", 32'(a_de), 0);
            if (i == 6) begin
                check("mid_de_d2", 32'(a_de), 1);
                check("mid_dout_d2", 32'(a_dout), 55);
            end
            if (i == 17) check("d9_vs_before", 32'(a_vs), 0);
            if (i == 18) check("d9_vs_at", 32'(a_vs), 1);
            if (i == 20) check("d9_de_before", 32'(a_de), 0);
            if (i == 21) begin
                check("d9_de_at", 32'(a_de), 1);
                check("d9_dout", 32'(a_dout), 77);
                check("d9_valid", 32'(a_valid), 1);
            end
        end

        // ---------------- DEPTH=4 overflow / underflow ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        delay_cfg = 4'd15;
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        tick();
        for (int i = 0; i <= 30; i++) begin
            drive(i == 0, 1'b0, (i >= 2 && i <= 7), (i >= 2 && i <= 7) ? 24'(i - 1) : 24'd0);
            tick();
            if (i == 4) check("ovf_not_full_yet", 32'(b_full), 0);
            if (i == 5) begin
                check("ovf_level4", 32'(b_level), 4);
                check("ovf_full", 32'(b_full), 1);
                check("ovf_flag_before", 32'(b_ovf), 0);
            end
            if (i == 6) check("ovf_flag", 32'(b_ovf), 32'(EXP_STS));
            if (i == 7) check("ovf_level_held", 32'(b_level), 4);
            if (i == 18) begin
                check("ovf_dout1", 32'(b_dout), 1);
                check("ovf_valid1", 32'(b_valid), 1);
            end
            if (i == 21) begin
                check("ovf_dout4", 32'(b_dout), 4);
                check("ovf_valid4", 32'(b_valid), 1);
                check("udf_flag_before", 32'(b_udf), 0);
                check("udf_empty", 32'(b_empty), 1);
            end
            if (i == 22) begin
                check("udf_valid", 32'(b_valid), 0);
                check("udf_dout_hold", 32'(b_dout), 4);
                check("udf_de_out", 32'(b_de), 1);
                check("udf_flag", 32'(b_udf), 32'(EXP_STS));
            end
        end

        // ---------------- clr_status behaviour ----------------
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("clr_ovf", 32'(b_ovf), 0);
        check("clr_udf", 32'(b_udf), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 24'd9);
            tick();
        end
        check("clr_fill_full", 32'(b_full), 1);
        drive(1'b0, 1'b0, 1'b1, 24'd9);
        clr_status = 1'b1;
        tick();
        check("clr_vs_event", 32'(b_ovf), 32'(EXP_STS));
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        tick();
        clr_status = 1'b0;
        check("clr_alone", 32'(b_ovf), 0);
        repeat (25) tick();
        check("drain_a_empty", 32'(a_empty), 1);

        // ---------------- asynchronous reset mid-burst ----------------
        for (int i = 0; i <= 5; i++) begin
            drive(i == 0, 1'b0, (i >= 1 && i <= 5), (i >= 1) ? 24'(200 + i) : 24'd0);
            tick();
        end
        check("pre_rst_level5", 32'(a_level), 5);
        check("pre_rst_dout", 32'(a_dout), 9);
        rst = 1'b1;
        #1;
        check("arst_level", 32'(a_level), 0);
        check("arst_empty", 32'(a_empty), 1);
        check("arst_dout", 32'(a_dout), 0);
        check("arst_valid", 32'(a_valid), 0);
        check("arst_de_out", 32'(a_de), 0);
        drive(1'b0, 1'b0, 1'b0, 24'd0);
        tick();
        rst = 1'b0;
        delay_cfg = 4'd0;
        for (int j = 0; j <= 6; j++) begin
            drive(j == 0, 1'b0, (j >= 2 && j <= 4), (j >= 2 && j <= 4) ? 24'(299 + j) : 24'd0);
            tick();
            if (j == 1) check("post_vs_d2", 32'(a_vs), 1);
            if (j == 3) begin
                check("post_dout1", 32'(a_dout), 301);
                check("post_valid1", 32'(a_valid), 1);
            end
            if (j == 5) check("post_dout3", 32'(a_dout), 303);
            if (j == 6) begin
                check("post_valid_end", 32'(a_valid), 0);
                check("post_level0", 32'(a_level), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
